// File: rtl/iter_divider_pkg.sv
// Shared types and constants for the iterative divider.
//   div_state_t : IDLE / BUSY / DONE control states
//   u64 / u128  : common operand / result widths
//   DIV_ITER_D  : iterations for a full-width divide
//   DIV_ITER_W  : iterations for a word (32-bit) divide
package iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef logic [63:0]  u64;
  typedef logic [127:0] u128;

  localparam int unsigned DIV_ITER_D = 64;
  localparam int unsigned DIV_ITER_W = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   rem, quo  : current partial remainder / quotient-dividend shift pair
//   divisor   : latched divisor
//   wordEn    : 1 = operate on the low WIDTH/2 bits only, upper halves forced to 0
//   rem_next, quo_next : state after shifting in one dividend bit and one quotient bit
module div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  input  logic             wordEn,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  localparam int unsigned HALF = WIDTH / 2;

  // Shifted remainder carries one extra bit: it can reach 2*divisor-1.
  logic [WIDTH:0]     sh_d;
  logic [WIDTH-1:0]   diff_d;
  logic               nb_d;
  logic [HALF:0]      sh_w;
  logic [HALF-1:0]    diff_w;
  logic               nb_w;

  always_comb begin
    sh_d   = {rem, quo[WIDTH-1]};
    nb_d   = (sh_d >= {1'b0, divisor});
    // Result is below divisor whenever it is kept, so the low WIDTH bits suffice.
    diff_d = sh_d[WIDTH-1:0] - divisor;

    sh_w   = {rem[HALF-1:0], quo[HALF-1]};
    nb_w   = (sh_w >= {1'b0, divisor[HALF-1:0]});
    diff_w = sh_w[HALF-1:0] - divisor[HALF-1:0];

    rem_next = '0;
    quo_next = '0;
    if (wordEn) begin
      rem_next = {HALF'(0), (nb_w ? diff_w : sh_w[HALF-1:0])};
      quo_next = {HALF'(0), quo[HALF-2:0], nb_w};
    end else begin
      rem_next = nb_d ? diff_d : sh_d[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], nb_d};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle unsigned restoring radix-2 divider, one quotient bit per cycle.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   valid      : request, held until done; dropping it aborts an op in flight
//   wordEn     : 1 = 32-bit divide on the low halves of a and b
//   a, b       : unsigned dividend / divisor
//   done       : one-cycle pulse while c carries a fresh result
//   busy       : high while iterating
//   c          : {remainder, quotient}, held until the next completion or reset
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_ITER_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 wordEn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   c
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  div_state_t       state;
  div_state_t       state_next;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             word;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .wordEn   (word),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; the last BUSY step is the one that still sees count==1
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (valid) state_next = BUSY;
      BUSY:    if (!valid) state_next = IDLE;
               else if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode directly from the state register
  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

  // Operand latch, iteration and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      word    <= 1'b0;
      count   <= '0;
      c       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid) begin
            word    <= wordEn;
            count   <= wordEn ? CW'(HALF) : CW'(WIDTH);
            rem     <= '0;
            quo     <= wordEn ? {HALF'(0), a[HALF-1:0]} : a;
            divisor <= wordEn ? {HALF'(0), b[HALF-1:0]} : b;
          end
        end
        BUSY: begin
          if (valid) begin
            rem   <= rem_n;
            quo   <= quo_n;
            count <= count - CW'(1);
            if (count == CW'(1)) c <= {rem_n, quo_n};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: tasks drive directed requests and push the
// hand-computed {remainder, quotient}; a negedge monitor pops and compares on done.
module tb_iter_divider;

  logic         clk;
  logic         reset;
  logic         valid;
  logic         wordEn;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         done;
  logic         busy;
  logic [127:0] c;

  int           tests;
  int           fails;
  logic [127:0] expq[$];
  logic [127:0] mon_exp;
  logic [127:0] last_c;

  iter_divider #(.WIDTH(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .wordEn (wordEn),
    .a      (a),
    .b      (b),
    .done   (done),
    .busy   (busy),
    .c      (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got c=%h expected no done", c);
      end else begin
        mon_exp = expq.pop_front();
        check("result", c, mon_exp);
      end
    end
  end

  // Counts rising edges until done is seen; called at a negedge
  task automatic wait_done(input string name, input int lat, input bit chk_busy);
    int n;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (chk_busy && n == 1) check({name, "_busy"}, 128'(busy), 128'(1));
      if (n > 1 && n < lat) begin
        if (done) begin
          check({name, "_early_done"}, 128'(done), 128'(0));
          break;
        end
      end
      if (done) break;
    end
    check({name, "_latency"}, 128'(n), 128'(lat));
  endtask

  task automatic run_op(input string name, input logic [63:0] aa, input logic [63:0] bb,
                        input logic w, input logic [127:0] exp, input int lat, input bit drop);
    a      = aa;
    b      = bb;
    wordEn = w;
    valid  = 1'b1;
    expq.push_back(exp);
    last_c = exp;
    wait_done(name, lat, 1'b1);
    if (drop) begin
      valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({name, "_pulse"}, 128'(done), 128'(0));
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    valid  = 1'b0;
    wordEn = 1'b0;
    a      = '0;
    b      = '0;
    last_c = '0;
    reset  = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("reset_done", 128'(done), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_c", c, 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Full-width and word-mode basics (upper input bits ignored in word mode)
    run_op("div64", 64'd100, 64'd7, 1'b0, {64'd2, 64'd14}, 65, 1'b1);
    run_op("div32", 64'hFFFFFFFF_00000064, 64'h5_00000007, 1'b1, {64'd2, 64'd14}, 33, 1'b1);

    // Divide by zero
    run_op("dz64", 64'h1234, 64'd0, 1'b0, {64'h1234, 64'hFFFF_FFFF_FFFF_FFFF}, 65, 1'b1);
    run_op("dz32", 64'h1234, 64'd0, 1'b1, {64'h1234, 64'h0000_0000_FFFF_FFFF}, 33, 1'b1);

    // Abort in BUSY cycle 10: no done, c keeps the previous result
    a = 64'd1000; b = 64'd3; wordEn = 1'b0; valid = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_c", c, last_c);
    repeat (80) @(negedge clk);
    run_op("after_abort", 64'd9, 64'd2, 1'b0, {64'd1, 64'd4}, 65, 1'b1);

    // Asynchronous reset in BUSY cycle 20
    a = 64'd1000; b = 64'd3; wordEn = 1'b0; valid = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_done", 128'(done), 128'(0));
    check("rst_mid_busy", 128'(busy), 128'(0));
    check("rst_mid_c", c, 128'(0));
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 1'b0,
           {64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF}, 65, 1'b1);

    // Back-to-back: valid held through DONE, operands switched in the DONE cycle
    run_op("b2b_first", 64'd100, 64'd7, 1'b0, {64'd2, 64'd14}, 65, 1'b0);
    a = 64'd50;
    b = 64'd5;
    expq.push_back({64'd0, 64'd10});
    wait_done("b2b_second", 66, 1'b0);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_pulse", 128'(done), 128'(0));

    repeat (5) @(negedge clk);
    check("queue_drained", 128'(expq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
